// File: rtl/qpu_ifu_imem_arb.sv
// qpu_ifu_imem_arb
// Shares the single instruction-memory port between the IFU fetch channel
// (read-only) and the host loader port (read/write). At most one memory
// transaction is outstanding at any time, and its response is routed back to
// whichever requester issued it. With a zero-wait-state memory the arbiter
// sustains one transaction per cycle, because a new grant may be issued in
// the same cycle that the outstanding response handshakes.

`ifndef QPU_PC_SIZE
`define QPU_PC_SIZE 32
`endif
`ifndef QPU_INSTR_SIZE
`define QPU_INSTR_SIZE 32
`endif

module qpu_ifu_imem_arb #(
   parameter int PC_SIZE        = `QPU_PC_SIZE,
   parameter int INSTR_SIZE     = `QPU_INSTR_SIZE,
   // Consecutive host grants allowed while the IFU is waiting (1..15).
   parameter int HOST_MAX_BURST = 4
) (
   input  logic                  clk,
   input  logic                  rst,

   // IFU fetch request / response
   input  logic                  ifu_req_valid,
   output logic                  ifu_req_ready,
   input  logic [PC_SIZE-1:0]    ifu_req_pc,
   input  logic                  ifu_req_seq,
   output logic                  ifu_rsp_valid,
   input  logic                  ifu_rsp_ready,
   output logic [INSTR_SIZE-1:0] ifu_rsp_instr,

   // Host loader request / response
   input  logic                  host_req_valid,
   output logic                  host_req_ready,
   input  logic                  host_req_write,
   input  logic [PC_SIZE-1:0]    host_req_addr,
   input  logic [INSTR_SIZE-1:0] host_req_wdata,
   output logic                  host_rsp_valid,
   input  logic                  host_rsp_ready,
   output logic [INSTR_SIZE-1:0] host_rsp_rdata,

   // Instruction memory controller
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic                  mem_req_write,
   output logic [PC_SIZE-1:0]    mem_req_addr,
   output logic [INSTR_SIZE-1:0] mem_req_wdata,
   input  logic                  mem_rsp_valid,
   output logic                  mem_rsp_ready,
   input  logic [INSTR_SIZE-1:0] mem_rsp_rdata,

   // Status
   output logic                  arb_busy
);

   // Requester indices; also the encoding of owner and lock owner.
   localparam logic SEL_IFU  = 1'b0;
   localparam logic SEL_HOST = 1'b1;

   localparam logic [3:0] BURST_LIMIT = 4'(HOST_MAX_BURST);
   localparam logic [3:0] BURST_SAT   = 4'hF;

   typedef enum logic {
      ST_IDLE = 1'b0,  // no outstanding transaction
      ST_OUTS = 1'b1   // one transaction outstanding, owned by owner_reg
   } state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t     state_reg;
   logic       owner_reg;       // requester that owns the outstanding transaction
   logic       lock_reg;        // a granted request is stalled on mem_req_ready
   logic       lock_owner_reg;  // requester holding the lock
   logic [3:0] burst_cnt_reg;   // host grants while the IFU was waiting

   // ------------------------------------------------------------------
   // Per-requester vectors, indexed by SEL_IFU / SEL_HOST
   // ------------------------------------------------------------------
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [1:0] rsp_ready;
   logic [1:0] rsp_valid;

   assign req_valid = {host_req_valid, ifu_req_valid};
   assign rsp_ready = {host_rsp_ready, ifu_rsp_ready};

   // ------------------------------------------------------------------
   // Response side
   // ------------------------------------------------------------------
   logic rsp_phase;          // outstanding transaction may be answered this cycle
   logic mem_rsp_ready_int;
   logic rsp_fire;           // outstanding response handshakes this cycle

   assign rsp_phase = ~rst & (state_reg == ST_OUTS);

   // Response ready: follow the owner in OUTS; in IDLE accept and discard
   // anything the memory presents (late responses of abandoned transactions).
   always_comb begin
      mem_rsp_ready_int = 1'b0;
      if (!rst) begin
         if (state_reg == ST_OUTS) begin
            mem_rsp_ready_int = rsp_ready[owner_reg];
         end else begin
            mem_rsp_ready_int = 1'b1;
         end
      end
   end

   assign rsp_fire = rsp_phase & mem_rsp_valid & mem_rsp_ready_int;

   // ------------------------------------------------------------------
   // Issue window and winner selection
   // ------------------------------------------------------------------
   logic can_issue;
   logic lock_live;     // lock still held by a requester that keeps its valid up
   logic host_capped;   // host has used up its burst allowance over a waiting IFU
   logic win_valid;
   logic win_sel;
   logic mem_req_valid_int;
   logic req_fire;      // memory request handshake this cycle

   assign can_issue   = ~rst & ((state_reg == ST_IDLE) | rsp_fire);
   assign lock_live   = lock_reg & req_valid[lock_owner_reg];
   assign host_capped = (burst_cnt_reg == BURST_LIMIT) & ifu_req_valid;

   // Winner: a live lock dominates, then the host unless capped, then the IFU.
   always_comb begin
      win_valid = 1'b0;
      win_sel   = SEL_IFU;
      if (lock_live) begin
         win_valid = 1'b1;
         win_sel   = lock_owner_reg;
      end else if (host_req_valid && !host_capped) begin
         win_valid = 1'b1;
         win_sel   = SEL_HOST;
      end else if (ifu_req_valid) begin
         win_valid = 1'b1;
         win_sel   = SEL_IFU;
      end
   end

   assign mem_req_valid_int = can_issue & win_valid;
   assign req_fire          = mem_req_valid_int & mem_req_ready;

   // Per-requester handshake and response-valid decode.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         assign req_ready[gi] = req_fire & (win_sel == (gi == 1));
         assign rsp_valid[gi] = rsp_phase & mem_rsp_valid & (owner_reg == (gi == 1));
      end
   endgenerate

   // Request mux: fields from the winner, IFU fetches are always reads with
   // zero write data, everything zero when nothing is being requested.
   always_comb begin
      mem_req_write = 1'b0;
      mem_req_addr  = '0;
      mem_req_wdata = '0;
      if (mem_req_valid_int) begin
         if (win_sel == SEL_HOST) begin
            mem_req_write = host_req_write;
            mem_req_addr  = host_req_addr;
            mem_req_wdata = host_req_wdata;
         end else begin
            mem_req_addr  = ifu_req_pc;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign mem_req_valid  = mem_req_valid_int;
   assign mem_rsp_ready  = mem_rsp_ready_int;
   assign ifu_req_ready  = req_ready[SEL_IFU];
   assign host_req_ready = req_ready[SEL_HOST];
   assign ifu_rsp_valid  = rsp_valid[SEL_IFU];
   assign host_rsp_valid = rsp_valid[SEL_HOST];
   assign ifu_rsp_instr  = rst ? '0 : mem_rsp_rdata;
   assign host_rsp_rdata = rst ? '0 : mem_rsp_rdata;
   assign arb_busy       = (state_reg == ST_OUTS);

   // The sequential-fetch hint carries no meaning for the memory port.
   logic unused_seq;
   assign unused_seq = ifu_req_seq;

   // ------------------------------------------------------------------
   // FSM, owner, lock and host burst counter
   // ------------------------------------------------------------------
   // Single sequential block: transaction state, ownership, stall lock, burst.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         owner_reg      <= SEL_IFU;
         lock_reg       <= 1'b0;
         lock_owner_reg <= SEL_IFU;
         burst_cnt_reg  <= 4'd0;
      end else begin
         // A request handshake always opens a new transaction, including the
         // back-to-back case where the previous response retires this cycle.
         if (req_fire) begin
            state_reg <= ST_OUTS;
            owner_reg <= win_sel;
         end else if (rsp_fire) begin
            state_reg <= ST_IDLE;
         end

         // Hold the grant on a stalled request so the memory never sees the
         // address change under a pending valid.
         if (mem_req_valid_int && !mem_req_ready) begin
            lock_reg       <= 1'b1;
            lock_owner_reg <= win_sel;
         end else if (req_fire) begin
            lock_reg <= 1'b0;
         end else if (lock_reg && !req_valid[lock_owner_reg]) begin
            lock_reg <= 1'b0;
         end

         // Host grants are only counted against an IFU that is actually waiting.
         if (!ifu_req_valid || req_ready[SEL_IFU]) begin
            burst_cnt_reg <= 4'd0;
         end else if (req_ready[SEL_HOST] && (burst_cnt_reg != BURST_SAT)) begin
            burst_cnt_reg <= burst_cnt_reg + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_qpu_ifu_imem_arb.sv
// Testbench for qpu_ifu_imem_arb: directed scenarios followed by a random
// phase, all checked against a transaction-level model of the memory and of
// each requester's expected responses.
`timescale 1ns/1ps

module tb_qpu_ifu_imem_arb;

   localparam int PC_SIZE    = 32;
   localparam int INSTR_SIZE = 32;
   localparam int MAXB       = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  ifu_req_valid, ifu_req_ready, ifu_req_seq;
   logic [PC_SIZE-1:0]    ifu_req_pc;
   logic                  ifu_rsp_valid, ifu_rsp_ready;
   logic [INSTR_SIZE-1:0] ifu_rsp_instr;
   logic                  host_req_valid, host_req_ready, host_req_write;
   logic [PC_SIZE-1:0]    host_req_addr;
   logic [INSTR_SIZE-1:0] host_req_wdata;
   logic                  host_rsp_valid, host_rsp_ready;
   logic [INSTR_SIZE-1:0] host_rsp_rdata;
   logic                  mem_req_valid, mem_req_ready, mem_req_write;
   logic [PC_SIZE-1:0]    mem_req_addr;
   logic [INSTR_SIZE-1:0] mem_req_wdata;
   logic                  mem_rsp_valid, mem_rsp_ready;
   logic [INSTR_SIZE-1:0] mem_rsp_rdata;
   logic                  arb_busy;

   qpu_ifu_imem_arb #(
      .PC_SIZE(PC_SIZE), .INSTR_SIZE(INSTR_SIZE), .HOST_MAX_BURST(MAXB)
   ) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
      .ifu_req_pc(ifu_req_pc), .ifu_req_seq(ifu_req_seq),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
      .ifu_rsp_instr(ifu_rsp_instr),
      .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
      .host_req_write(host_req_write), .host_req_addr(host_req_addr),
      .host_req_wdata(host_req_wdata),
      .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
      .host_rsp_rdata(host_rsp_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
      .mem_rsp_rdata(mem_rsp_rdata),
      .arb_busy(arb_busy)
   );

   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chks(input string tag, input string obs, input string exp);
      checks++;
      assert (obs == exp) else begin
         errors++;
         $error("FAIL %s: observed=%s expected=%s", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { logic [31:0] data; int avail; } mrsp_t;
   typedef struct { logic w; logic [31:0] addr; logic [31:0] data; } hreq_t;

   logic [31:0] mem_arr [0:255];   // word-addressed, addr[9:2]
   mrsp_t       mq[$];             // responses the memory will return, in order
   logic [31:0] ifu_todo[$];       // IFU PCs still to be presented
   hreq_t       host_todo[$];      // host requests still to be presented
   logic [31:0] ifu_exp[$];        // expected IFU response data
   hreq_t       host_exp[$];       // expected host responses (w flag, read data)
   logic [31:0] ifu_got[$];        // IFU response data as received

   int    out_owner;   // 0 none, 1 IFU, 2 host: who owns the memory transaction
   int    hcnt;        // host grants since the IFU started waiting
   string grant_log;
   int    cyc;
   int    mem_rdy_mode, ifu_rdy_mode, host_rdy_mode;  // 0 low, 1 high, 2 random
   int    lat_min, lat_max;
   int    ifu_rsp_cnt, host_rsp_cnt, host_rsp_vcnt, stray_cnt;
   int    last_grant_cyc, gap_cnt;
   logic [31:0] last_ifu_data;

   function automatic logic pick(input int mode);
      if (mode == 2) return 1'($urandom_range(0, 1));
      return (mode != 0);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'(a[9:2]);
   endfunction

   function automatic logic [31:0] raddr();
      logic [7:0] w;
      w = 8'($urandom_range(0, 255));
      return {22'd0, w, 2'b00};
   endfunction

   // Drive one cycle of inputs from the model, then let the DUT settle.
   task automatic cycle_begin();
      ifu_req_valid  = (ifu_todo.size() > 0);
      ifu_req_pc     = ifu_req_valid ? ifu_todo[0] : $urandom;
      ifu_req_seq    = 1'($urandom_range(0, 1));
      host_req_valid = (host_todo.size() > 0);
      host_req_write = host_req_valid ? host_todo[0].w    : 1'($urandom_range(0, 1));
      host_req_addr  = host_req_valid ? host_todo[0].addr : $urandom;
      host_req_wdata = host_req_valid ? host_todo[0].data : $urandom;
      mem_req_ready  = pick(mem_rdy_mode);
      ifu_rsp_ready  = pick(ifu_rdy_mode);
      host_rsp_ready = pick(host_rdy_mode);
      mem_rsp_valid  = (mq.size() > 0) && (cyc >= mq[0].avail);
      mem_rsp_rdata  = mem_rsp_valid ? mq[0].data : $urandom;
      #2;
   endtask

   // Check the settled outputs against the model, advance the model, clock.
   task automatic cycle_end();
      logic ifu_hs, host_hs, mreq_hs, mrsp_hs, irsp_hs, hrsp_hs;
      logic [31:0] d;
      int lat;
      ifu_hs  = ifu_req_valid & ifu_req_ready;
      host_hs = host_req_valid & host_req_ready;
      mreq_hs = mem_req_valid & mem_req_ready;
      mrsp_hs = mem_rsp_valid & mem_rsp_ready;
      irsp_hs = ifu_rsp_valid & ifu_rsp_ready;
      hrsp_hs = host_rsp_valid & host_rsp_ready;
      if (!rst) begin
         chkb("ifu_rsp_valid_route", ifu_rsp_valid, mem_rsp_valid && out_owner == 1);
         chkb("host_rsp_valid_route", host_rsp_valid, mem_rsp_valid && out_owner == 2);
         chkb("mem_rsp_ready_route", mem_rsp_ready,
              (out_owner == 0) ? 1'b1 : (out_owner == 1) ? ifu_rsp_ready : host_rsp_ready);
         chkb("arb_busy", arb_busy, out_owner != 0);
         chk("grant_count", 32'(ifu_hs) + 32'(host_hs), 32'(mreq_hs));
         if (mreq_hs) chkb("issue_window", (out_owner == 0) || mrsp_hs, 1'b1);
         if (ifu_hs) begin
            chk("ifu_fwd_addr", mem_req_addr, ifu_req_pc);
            chkb("ifu_fwd_write", mem_req_write, 1'b0);
            chk("ifu_fwd_wdata", mem_req_wdata, 32'd0);
         end
         if (host_hs) begin
            chk("host_fwd_addr", mem_req_addr, host_req_addr);
            chkb("host_fwd_write", mem_req_write, host_req_write);
            chk("host_fwd_wdata", mem_req_wdata, host_req_wdata);
            if (ifu_req_valid) chkb("host_burst_limit", hcnt < MAXB, 1'b1);
         end
         if (irsp_hs) begin
            if (ifu_exp.size() == 0) chkb("ifu_rsp_unexpected", 1'b1, 1'b0);
            else chk("ifu_rsp_data", ifu_rsp_instr, ifu_exp[0]);
         end
         if (hrsp_hs) begin
            if (host_exp.size() == 0) chkb("host_rsp_unexpected", 1'b1, 1'b0);
            else if (!host_exp[0].w) chk("host_rsp_data", host_rsp_rdata, host_exp[0].data);
         end
      end

      if (rst) begin
         out_owner = 0;
         hcnt      = 0;
         ifu_exp.delete();
         host_exp.delete();
      end else begin
         if (host_rsp_valid) host_rsp_vcnt++;
         if (mrsp_hs) begin
            if (out_owner == 0) stray_cnt++;
            void'(mq.pop_front());
            out_owner = 0;
         end
         if (irsp_hs && ifu_exp.size() > 0) begin
            void'(ifu_exp.pop_front());
            ifu_rsp_cnt++;
            last_ifu_data = ifu_rsp_instr;
            ifu_got.push_back(ifu_rsp_instr);
         end
         if (hrsp_hs && host_exp.size() > 0) begin
            void'(host_exp.pop_front());
            host_rsp_cnt++;
         end
         if (mreq_hs) begin
            if (last_grant_cyc >= 0 && cyc - last_grant_cyc != 1) gap_cnt++;
            last_grant_cyc = cyc;
            $display("[%0d] grant %s addr=%h write=%b wdata=%h", cyc,
                     ifu_hs ? "IFU " : "HOST", mem_req_addr, mem_req_write, mem_req_wdata);
         end
         lat = $urandom_range(lat_min, lat_max);
         if (ifu_hs) begin
            d = mem_arr[widx(ifu_req_pc)];
            ifu_exp.push_back(d);
            mq.push_back('{data: d, avail: cyc + lat});
            void'(ifu_todo.pop_front());
            out_owner = 1;
            grant_log = {grant_log, "I"};
         end
         if (host_hs) begin
            d = mem_arr[widx(host_req_addr)];
            host_exp.push_back('{w: host_req_write, addr: host_req_addr, data: d});
            if (host_req_write) begin
               mem_arr[widx(host_req_addr)] = host_req_wdata;
               d = $urandom;
            end
            mq.push_back('{data: d, avail: cyc + lat});
            void'(host_todo.pop_front());
            out_owner = 2;
            grant_log = {grant_log, "H"};
         end
         if (!ifu_req_valid || ifu_hs) hcnt = 0;
         else if (host_hs) hcnt++;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic logic all_done();
      return ifu_todo.size() == 0 && host_todo.size() == 0 && ifu_exp.size() == 0 &&
             host_exp.size() == 0 && mq.size() == 0;
   endfunction

   task automatic drain(input string tag, input int budget);
      int k;
      k = 0;
      while (k < budget && !all_done()) begin
         cycle_begin();
         cycle_end();
         k++;
      end
      chkb({tag, "_drained"}, all_done(), 1'b1);
   endtask

   task automatic clear_stats();
      grant_log      = "";
      ifu_rsp_cnt    = 0;
      host_rsp_cnt   = 0;
      host_rsp_vcnt  = 0;
      stray_cnt      = 0;
      last_grant_cyc = -1;
      gap_cnt        = 0;
      ifu_got.delete();
   endtask

   initial begin
      hreq_t h;
      for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
      cyc = 0; out_owner = 0; hcnt = 0; last_ifu_data = '0;
      mem_rdy_mode = 1; ifu_rdy_mode = 1; host_rdy_mode = 1;
      lat_min = 1; lat_max = 1;
      clear_stats();
      rst = 1'b1;
      ifu_req_valid = 1'b0; ifu_req_pc = '0; ifu_req_seq = 1'b0; ifu_rsp_ready = 1'b0;
      host_req_valid = 1'b0; host_req_write = 1'b0; host_req_addr = '0; host_req_wdata = '0;
      host_rsp_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
      @(posedge clk);
      #1;

      // ---- reset state: every valid/ready/data output zero under busy inputs
      for (int k = 0; k < 2; k++) begin
         ifu_req_valid = 1'b1; ifu_req_pc = $urandom; ifu_rsp_ready = 1'b1;
         host_req_valid = 1'b1; host_req_write = 1'b1;
         host_req_addr = $urandom; host_req_wdata = $urandom; host_rsp_ready = 1'b1;
         mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = $urandom | 32'h1;
         #2;
         chkb("rst_mem_req_valid", mem_req_valid, 1'b0);
         chkb("rst_ifu_req_ready", ifu_req_ready, 1'b0);
         chkb("rst_host_req_ready", host_req_ready, 1'b0);
         chkb("rst_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
         chkb("rst_host_rsp_valid", host_rsp_valid, 1'b0);
         chkb("rst_mem_rsp_ready", mem_rsp_ready, 1'b0);
         chk("rst_mem_req_addr", mem_req_addr, 32'd0);
         chk("rst_mem_req_wdata", mem_req_wdata, 32'd0);
         chkb("rst_mem_req_write", mem_req_write, 1'b0);
         chk("rst_ifu_rsp_instr", ifu_rsp_instr, 32'd0);
         chk("rst_host_rsp_rdata", host_rsp_rdata, 32'd0);
         @(posedge clk);
         #1;
         cyc++;
      end
      rst = 1'b0;

      // ---- idle after reset
      cycle_begin();
      chkb("idle_busy", arb_busy, 1'b0);
      chkb("idle_mem_rsp_ready", mem_rsp_ready, 1'b1);
      chkb("idle_mem_req_valid", mem_req_valid, 1'b0);
      cycle_end();

      // ---- IFU-only stream, zero-wait memory
      clear_stats();
      for (int i = 0; i < 8; i++) begin
         mem_arr[i] = (32'(i) * 32'd4) ^ 32'hA5A5A5A5;
         ifu_todo.push_back(32'(i) * 32'd4);
      end
      for (int k = 0; k < 40 && ifu_rsp_cnt < 8; k++) begin
         cycle_begin();
         cycle_end();
      end
      chk("t1_ifu_rsp_count", 32'(ifu_rsp_cnt), 32'd8);
      chks("t1_grant_order", grant_log, "IIIIIIII");
      chk("t1_issue_gaps", 32'(gap_cnt), 32'd0);
      chk("t1_host_rsp_valid_cycles", 32'(host_rsp_vcnt), 32'd0);
      for (int i = 0; i < 8; i++)
         if (i < ifu_got.size()) chk("t1_ifu_data", ifu_got[i], (32'(i) * 32'd4) ^ 32'hA5A5A5A5);
      drain("t1", 10);

      // ---- both requesters valid from reset release, host burst limit
      clear_stats();
      ifu_todo.push_back(32'h200);
      ifu_todo.push_back(32'h204);
      for (int i = 0; i < 8; i++) begin
         h.w = 1'b1; h.addr = 32'h100 + 32'(i) * 32'd4; h.data = $urandom;
         host_todo.push_back(h);
      end
      rst = 1'b1;
      cycle_begin();
      cycle_end();
      rst = 1'b0;
      drain("t2", 60);
      chks("t2_grant_order", grant_log, "HHHHIHHHHI");
      chk("t2_host_rsp_count", 32'(host_rsp_cnt), 32'd8);

      // ---- stall lock: IFU granted, memory stalls, host rises meanwhile
      clear_stats();
      ifu_todo.push_back(32'h20);
      mem_rdy_mode = 0;
      for (int k = 0; k < 3; k++) begin
         cycle_begin();
         chkb("t3_mem_req_valid", mem_req_valid, 1'b1);
         chk("t3_mem_req_addr", mem_req_addr, 32'h20);
         chkb("t3_host_req_ready", host_req_ready, 1'b0);
         chkb("t3_ifu_req_ready", ifu_req_ready, 1'b0);
         cycle_end();
         if (k == 0) begin
            h.w = 1'b0; h.addr = 32'h40; h.data = 32'd0;
            host_todo.push_back(h);
         end
      end
      mem_rdy_mode = 1;
      cycle_begin();
      chkb("t3_ifu_granted", ifu_req_ready, 1'b1);
      chkb("t3_host_held_off", host_req_ready, 1'b0);
      cycle_end();
      cycle_begin();
      chkb("t3_ifu_rsp", ifu_rsp_valid, 1'b1);
      chkb("t3_host_after_rsp", host_req_ready, 1'b1);
      cycle_end();
      drain("t3", 10);
      chks("t3_grant_order", grant_log, "IH");

      // ---- response backpressure from the host
      clear_stats();
      h.w = 1'b0; h.addr = 32'h40; h.data = 32'd0;
      host_todo.push_back(h);
      ifu_todo.push_back(32'h44);
      host_rdy_mode = 0;
      cycle_begin();
      chkb("t4_host_granted", host_req_ready, 1'b1);
      cycle_end();
      for (int k = 0; k < 2; k++) begin
         cycle_begin();
         chkb("t4_rsp_pending", mem_rsp_valid, 1'b1);
         chkb("t4_mem_rsp_ready", mem_rsp_ready, 1'b0);
         chkb("t4_no_grant", mem_req_valid, 1'b0);
         chkb("t4_busy", arb_busy, 1'b1);
         cycle_end();
      end
      host_rdy_mode = 1;
      cycle_begin();
      chkb("t4_rsp_hs", mem_rsp_ready, 1'b1);
      chkb("t4_host_rsp_valid", host_rsp_valid, 1'b1);
      chkb("t4_b2b_ifu_grant", ifu_req_ready, 1'b1);
      cycle_end();
      drain("t4", 10);

      // ---- host write, then IFU fetch of the same word
      clear_stats();
      h.w = 1'b1; h.addr = 32'h40; h.data = 32'hDEADBEEF;
      host_todo.push_back(h);
      drain("t5w", 10);
      ifu_todo.push_back(32'h40);
      drain("t5r", 10);
      chk("t5_host_rsp_count", 32'(host_rsp_cnt), 32'd1);
      chk("t5_ifu_data", last_ifu_data, 32'hDEADBEEF);

      // ---- reset in the middle of an outstanding transaction
      clear_stats();
      lat_min = 4; lat_max = 4;
      ifu_todo.push_back(32'h60);
      cycle_begin();
      chkb("t6_ifu_granted", ifu_req_ready, 1'b1);
      cycle_end();
      rst = 1'b1;
      cycle_begin();
      cycle_end();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cycle_begin();
         chkb("t6_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
         chkb("t6_host_rsp_valid", host_rsp_valid, 1'b0);
         chkb("t6_idle", arb_busy, 1'b0);
         if (mem_rsp_valid) chkb("t6_absorb_ready", mem_rsp_ready, 1'b1);
         cycle_end();
      end
      chk("t6_stray_absorbed", 32'(stray_cnt), 32'd1);
      chk("t6_ifu_rsp_count", 32'(ifu_rsp_cnt), 32'd0);
      chkb("t6_mem_drained", mq.size() == 0, 1'b1);
      lat_min = 1; lat_max = 1;

      // ---- random traffic
      clear_stats();
      mem_rdy_mode = 2; ifu_rdy_mode = 2; host_rdy_mode = 2;
      lat_min = 1; lat_max = 3;
      for (int k = 0; k < 1500; k++) begin
         if (ifu_todo.size() == 0 && $urandom_range(0, 2) == 0) ifu_todo.push_back(raddr());
         if (host_todo.size() == 0 && $urandom_range(0, 2) == 0) begin
            h.w = 1'($urandom_range(0, 1)); h.addr = raddr(); h.data = $urandom;
            host_todo.push_back(h);
         end
         cycle_begin();
         cycle_end();
      end
      mem_rdy_mode = 1; ifu_rdy_mode = 1; host_rdy_mode = 1;
      drain("rand", 200);
      chkb("rand_progress", (ifu_rsp_cnt > 50) && (host_rsp_cnt > 50), 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
